// File: rtl/video_stream_tx_pkg.sv
// video_stream_tx_pkg: shared types and defaults for the video stream
// transmitter and its skid FIFO.
package video_stream_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP,
        DONE
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_LINE_GAP = 16;
    localparam int ADDR_W       = 19;
    localparam int PIX_W        = 24;
    localparam int BEAT_W       = PIX_W + 2;

endpackage

// File: rtl/vid_skid_fifo.sv
// vid_skid_fifo: 2-entry FIFO holding {tuser, tlast, tdata} beats.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, count.
module vid_skid_fifo
    import video_stream_tx_pkg::*;
#(
    parameter int W = BEAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic         wr_sel;
    logic         rd_sel;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // a full FIFO may still take a beat when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = rd_sel ? ent1 : ent0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0   <= '0;
            ent1   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_sel) begin
                    ent1 <= din;
                end else begin
                    ent0 <= din;
                end
                wr_sel <= !wr_sel;
            end
            if (do_pop) begin
                rd_sel <= !rd_sel;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_tx.sv
// video_stream_tx: reads a frame from pixel memory and streams it as
// AXI4-Stream video (tuser = SOF, tlast = EOL).
// Ports: Cclk, rst (sync, active-high); FrameStart, Continuous controls;
// Ren/Radd/Rdata memory read port (1-cycle latency); m_axis_video_*
// stream; Busy, FrameDone pulse, FraimSync toggle per accepted SOF.
module video_stream_tx
    import video_stream_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int LINE_GAP = DEF_LINE_GAP
) (
    input  logic              Cclk,
    input  logic              rst,
    input  logic              FrameStart,
    input  logic              Continuous,
    output logic              Ren,
    output logic [ADDR_W-1:0] Radd,
    input  logic [PIX_W-1:0]  Rdata,
    output logic [PIX_W-1:0]  m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic              Busy,
    output logic              FrameDone,
    output logic              FraimSync
);

    localparam logic [11:0] PIX_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] LINE_LAST = 12'(V_ACTIVE - 1);
    localparam bit          HAS_GAP   = (LINE_GAP > 0);
    // The first beat of the next line shows up two cycles after its read,
    // so the GAP state releases two cycles early to make the idle stretch
    // on the stream equal LINE_GAP (minimum two cycles).
    localparam bit          SHORT_GAP = (LINE_GAP <= 2);
    localparam logic [15:0] GAP_LOAD  = SHORT_GAP ? 16'd0 : 16'(LINE_GAP - 3);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   radd;
    logic [11:0]         pix;
    logic [11:0]         line;
    logic                rd_pend;
    logic                rd_user;
    logic                rd_last;
    logic                gap_armed;
    logic [15:0]         gap_cnt;
    logic                frame_done;
    logic                fraim_sync;

    logic                ren;
    logic                pop;
    logic                restart;
    logic                gap_load;
    logic                done_evt;
    logic                line_end;
    logic                frame_end;
    logic                last_pop;
    logic [2:0]          occ;
    logic [1:0]          fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [BEAT_W-1:0]   fifo_dout;

    vid_skid_fifo #(
        .W(BEAT_W)
    ) u_fifo (
        .clk   (Cclk),
        .rst   (rst),
        .push  (rd_pend),
        .din   ({rd_user, rd_last, Rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_axis_video_tvalid = !fifo_empty;
    assign m_axis_video_tuser  = fifo_dout[PIX_W+1];
    assign m_axis_video_tlast  = fifo_dout[PIX_W];
    assign m_axis_video_tdata  = fifo_dout[PIX_W-1:0];

    assign pop       = m_axis_video_tvalid && m_axis_video_tready;
    assign line_end  = (pix == PIX_LAST);
    assign frame_end = line_end && (line == LINE_LAST);
    // in DONE no reads are issued, so the last buffered beat is the frame end
    assign last_pop  = pop && (fifo_count == 2'd1) && !rd_pend;

    // The read in flight always holds a slot; the beat leaving this
    // cycle frees one, which keeps a full line at one beat per cycle.
    assign occ = {1'b0, fifo_count} + {2'b00, rd_pend};
    assign ren = (state == ACTIVE)
               && (occ < (pop ? 3'd3 : 3'd2))
               && (!fifo_full || pop);

    assign Ren       = ren;
    assign Radd      = radd;
    assign Busy      = (state != IDLE);
    assign FrameDone = frame_done;
    assign FraimSync = fraim_sync;

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        gap_load  = 1'b0;
        done_evt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (FrameStart) begin
                    state_nxt = ACTIVE;
                    restart   = 1'b1;
                end
            end
            ACTIVE: begin
                if (ren && frame_end) begin
                    state_nxt = DONE;
                end else if (ren && line_end && HAS_GAP) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (!gap_armed) begin
                    if (pop && m_axis_video_tlast) begin
                        if (SHORT_GAP) begin
                            state_nxt = ACTIVE;
                        end else begin
                            gap_load = 1'b1;
                        end
                    end
                end else if (gap_cnt == 16'd0) begin
                    state_nxt = ACTIVE;
                end
            end
            DONE: begin
                if (last_pop) begin
                    done_evt = 1'b1;
                    if (Continuous) begin
                        state_nxt = ACTIVE;
                        restart   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            rd_user    <= 1'b0;
            rd_last    <= 1'b0;
            frame_done <= 1'b0;
            fraim_sync <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pend    <= ren;
            rd_user    <= (pix == 12'd0) && (line == 12'd0);
            rd_last    <= line_end;
            frame_done <= done_evt;
            if (pop && m_axis_video_tuser) begin
                fraim_sync <= !fraim_sync;
            end
        end
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            radd <= '0;
            pix  <= 12'd0;
            line <= 12'd0;
        end else if (restart) begin
            radd <= '0;
            pix  <= 12'd0;
            line <= 12'd0;
        end else if (ren) begin
            radd <= radd + 1'b1;
            if (line_end) begin
                pix  <= 12'd0;
                line <= frame_end ? 12'd0 : line + 12'd1;
            end else begin
                pix <= pix + 12'd1;
            end
        end
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            gap_armed <= 1'b0;
            gap_cnt   <= 16'd0;
        end else if (gap_load) begin
            gap_armed <= 1'b1;
            gap_cnt   <= GAP_LOAD;
        end else if (gap_armed) begin
            if (gap_cnt == 16'd0) begin
                gap_armed <= 1'b0;
            end else begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_tx.sv
// tb_video_stream_tx: directed bench for video_stream_tx with a 4x2 frame,
// one instance without line gap (u0) and one with a 3-cycle gap (u3).
module tb_video_stream_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        continuous = 1'b0;
    logic        tready = 1'b1;

    logic        ren0, ren3;
    logic [18:0] radd0, radd3;
    logic [23:0] rdata0 = '0, rdata3 = '0;
    logic [23:0] tdata0, tdata3;
    logic        tvalid0, tvalid3, tuser0, tuser3, tlast0, tlast3;
    logic        busy0, busy3, fdone0, fdone3, fsync0, fsync3;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fs_edge = 0;
    int tog0 = 0;
    int stall_n = 0;
    logic fs_prev = 1'b0;
    bit stab_on = 1'b0;
    bit hold_v = 1'b0;
    logic [25:0] hold_b = '0;

    logic [23:0] dq0[$], dq3[$];
    logic uq0[$], uq3[$], lq0[$], lq3[$];
    int cq0[$], cq3[$], fdq0[$];

    video_stream_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .LINE_GAP(0)
    ) u0 (
        .Cclk(clk), .rst(rst), .FrameStart(frame_start),
        .Continuous(continuous), .Ren(ren0), .Radd(radd0), .Rdata(rdata0),
        .m_axis_video_tdata(tdata0), .m_axis_video_tvalid(tvalid0),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser0),
        .m_axis_video_tlast(tlast0), .Busy(busy0), .FrameDone(fdone0),
        .FraimSync(fsync0)
    );

    video_stream_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .LINE_GAP(3)
    ) u3 (
        .Cclk(clk), .rst(rst), .FrameStart(frame_start),
        .Continuous(continuous), .Ren(ren3), .Radd(radd3), .Rdata(rdata3),
        .m_axis_video_tdata(tdata3), .m_axis_video_tvalid(tvalid3),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser3),
        .m_axis_video_tlast(tlast3), .Busy(busy3), .FrameDone(fdone3),
        .FraimSync(fsync3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren0) rdata0 <= {5'd0, radd0};
        if (ren3) rdata3 <= {5'd0, radd3};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // observe at negedge, then advance to just after the next posedge
    task automatic tick();
        @(negedge clk);
        if (tvalid0 === 1'b1 && tready) begin
            dq0.push_back(tdata0);
            uq0.push_back(tuser0);
            lq0.push_back(tlast0);
            cq0.push_back(cyc);
        end
        if (tvalid3 === 1'b1 && tready) begin
            dq3.push_back(tdata3);
            uq3.push_back(tuser3);
            lq3.push_back(tlast3);
            cq3.push_back(cyc);
        end
        if (fdone0 === 1'b1) fdq0.push_back(cyc);
        if (fsync0 !== fs_prev) tog0++;
        fs_prev = fsync0;
        if (stab_on && hold_v) begin
            stall_n++;
            chk("stall_valid", tvalid0, 1);
            chk("stall_beat", {tuser0, tlast0, tdata0}, hold_b);
        end
        hold_v = stab_on && (tvalid0 === 1'b1) && !tready;
        hold_b = {tuser0, tlast0, tdata0};
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        dq0.delete(); uq0.delete(); lq0.delete(); cq0.delete();
        dq3.delete(); uq3.delete(); lq3.delete(); cq3.delete();
        fdq0.delete();
        tog0 = 0;
        fs_prev = fsync0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        continuous = 1'b0;
        tready = 1'b1;
        run(2);
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic pulse_fs();
        fs_edge = cyc + 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic chk_frames(input string tg, input bit g3, input int n);
        int sz;
        sz = g3 ? dq3.size() : dq0.size();
        chk({tg, "_nbeats"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            logic [23:0] d;
            logic u, l;
            d = g3 ? dq3[i] : dq0[i];
            u = g3 ? uq3[i] : uq0[i];
            l = g3 ? lq3[i] : lq0[i];
            chk({tg, "_tdata"}, d, i % 8);
            chk({tg, "_tuser"}, u, (i % 8) == 0);
            chk({tg, "_tlast"}, l, (i % 4) == 3);
        end
    endtask

    initial begin
        // reset state, observed while rst is still high
        run(2);
        chk("rst_tvalid", tvalid0, 0);
        chk("rst_tuser", tuser0, 0);
        chk("rst_tlast", tlast0, 0);
        chk("rst_tdata", tdata0, 0);
        chk("rst_ren", ren0, 0);
        chk("rst_radd", radd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_fdone", fdone0, 0);
        chk("rst_fsync", fsync0, 0);
        rst = 1'b0;
        tick();
        clear_logs();

        // 1: plain frame, tready=1
        pulse_fs();
        chk("s1_busy", busy0, 1);
        run(20);
        chk_frames("s1", 1'b0, 8);
        chk("s1_latency", cq0[0], fs_edge + 2);
        chk("s1_thruput", cq0[7] - cq0[0], 7);
        chk("s1_fd_n", fdq0.size(), 1);
        chk("s1_fd_cyc", fdq0[0], cq0[7] + 1);
        chk("s1_busy_end", busy0, 0);

        // 2: alternating tready plus a 5-cycle stall
        do_reset();
        stab_on = 1'b1;
        stall_n = 0;
        for (int t = 0; t < 60; t++) begin
            frame_start = (t == 0);
            tready = (t >= 5 && t < 10) ? 1'b0 : ((t % 2) == 0);
            tick();
        end
        frame_start = 1'b0;
        tready = 1'b1;
        stab_on = 1'b0;
        run(4);
        chk_frames("s2", 1'b0, 8);
        chk("s2_stalls_seen", stall_n >= 5, 1);
        chk("s2_fd_n", fdq0.size(), 1);

        // 3: LINE_GAP=3 instance
        do_reset();
        pulse_fs();
        run(30);
        chk_frames("s3", 1'b1, 8);
        chk("s3_gap", cq3[4] - cq3[3], 4);
        chk("s3_line0", cq3[3] - cq3[0], 3);
        chk("s3_line1", cq3[7] - cq3[4], 3);

        // 4: continuous for three frames
        do_reset();
        continuous = 1'b1;
        pulse_fs();
        for (int i = 0; i < 120; i++) begin
            if (dq0.size() >= 17) continuous = 1'b0;
            tick();
        end
        continuous = 1'b0;
        chk_frames("s4", 1'b0, 24);
        chk("s4_fsync_toggles", tog0, 3);
        chk("s4_fd_n", fdq0.size(), 3);
        chk("s4_busy_end", busy0, 0);

        // 5: FrameStart while busy is ignored
        do_reset();
        pulse_fs();
        for (int i = 0; i < 20; i++) begin
            if (dq0.size() >= 2) break;
            tick();
        end
        pulse_fs();
        run(30);
        chk_frames("s5", 1'b0, 8);
        chk("s5_fd_n", fdq0.size(), 1);
        chk("s5_busy_end", busy0, 0);

        // 6: reset during a stalled beat 5, then clean restart
        do_reset();
        pulse_fs();
        for (int i = 0; i < 30; i++) begin
            if (dq0.size() >= 5) break;
            tick();
        end
        tready = 1'b0;
        run(2);
        chk("s6_stalled_valid", tvalid0, 1);
        chk("s6_stalled_data", tdata0, 5);
        rst = 1'b1;
        tick();
        chk("s6_rst_tvalid", tvalid0, 0);
        chk("s6_rst_busy", busy0, 0);
        chk("s6_rst_radd", radd0, 0);
        chk("s6_rst_ren", ren0, 0);
        chk("s6_rst_tlast", tlast0, 0);
        rst = 1'b0;
        tready = 1'b1;
        run(5);
        chk("s6_quiet_beats", dq0.size(), 5);
        chk("s6_quiet_fd", fdq0.size(), 0);
        clear_logs();
        pulse_fs();
        run(20);
        chk_frames("s6r", 1'b0, 8);
        chk("s6r_latency", cq0[0], fs_edge + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
